axi_lite_master: RTL and testbench

Single-outstanding AXI4-Lite initiator. It converts a simple command/response valid-ready interface into AXI4-Lite read and write transactions. It drives scratchpads and register slaves from bring-up sequencers and test controllers. Exactly one transaction is in flight; read/write ordering is therefore strict by construction.

---
 rtl/axi_lite_pkg.sv | 9 +
 rtl/axi_lite_master_timer.sv | 19 +
 rtl/axi_lite_master.sv | 142 ++++++++++++++
 tb/tb_axi_lite_master.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/axi_lite_pkg.sv
// axi_lite_pkg: AXI4-Lite response codes and master FSM states.
// Shared by the AXI-Lite master and the scratchpad slave.
package axi_lite_pkg;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;
  typedef enum logic [2:0] {IDLE, WRITE, WR_RESP, RD_ADDR, RD_DATA, RSP, HUNG} state_t;
endpackage

// File: rtl/axi_lite_master_timer.sv
// axi_lite_master_timer: busy-cycle counter that flags expiry after CYCLES_p enabled cycles.
// The count holds once expired.
module axi_lite_master_timer #(
  parameter int CYCLES_p = 1024
) (
  input  logic clk,
  input  logic rst_n,
  input  logic enable,
  input  logic clear,
  output logic expired
);
  localparam int W = $clog2(CYCLES_p + 1);
  logic [W-1:0] cnt;
  assign expired = cnt == W'(CYCLES_p);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else if (clear) cnt <= '0;
    else if (enable && !expired) cnt <= cnt + W'(1);
endmodule

// File: rtl/axi_lite_master.sv
// axi_lite_master: single-outstanding AXI4-Lite initiator bridging a cmd/rsp handshake to AXI.
// Define AXI_LITE_MASTER_TIMEOUT_EN to add a timeout that answers DECERR and then parks in HUNG.
module axi_lite_master
  import axi_lite_pkg::*;
#(
  parameter int ADDR_BW_p        = 12,
  parameter int DATA_BW_p        = 32,
  parameter int TIMEOUT_CYCLES_p = 1024
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   i_cmd_valid,
  output logic                   o_cmd_ready,
  input  logic                   i_cmd_write,
  input  logic [ADDR_BW_p-1:0]   i_cmd_addr,
  input  logic [DATA_BW_p-1:0]   i_cmd_wdata,
  input  logic [DATA_BW_p/8-1:0] i_cmd_wstrb,
  output logic                   o_rsp_valid,
  input  logic                   i_rsp_ready,
  output logic                   o_rsp_write,
  output logic [DATA_BW_p-1:0]   o_rsp_rdata,
  output logic [1:0]             o_rsp_resp,
  output logic [ADDR_BW_p-1:0]   o_axi_awaddr,
  output logic                   o_axi_awvalid,
  input  logic                   i_axi_awready,
  output logic [DATA_BW_p-1:0]   o_axi_wdata,
  output logic [DATA_BW_p/8-1:0] o_axi_wstrb,
  output logic                   o_axi_wvalid,
  input  logic                   i_axi_wready,
  input  logic [1:0]             i_axi_bresp,
  input  logic                   i_axi_bvalid,
  output logic                   o_axi_bready,
  output logic [ADDR_BW_p-1:0]   o_axi_araddr,
  output logic                   o_axi_arvalid,
  input  logic                   i_axi_arready,
  input  logic [DATA_BW_p-1:0]   i_axi_rdata,
  input  logic [1:0]             i_axi_rresp,
  input  logic                   i_axi_rvalid,
  output logic                   o_axi_rready
`ifdef AXI_LITE_MASTER_TIMEOUT_EN
  ,output logic                  o_timeout
`endif
);
  if (DATA_BW_p != 32 && DATA_BW_p != 64) begin : g_bad_data_bw
    $error("DATA_BW_p must be 32 or 64");
  end
  if (TIMEOUT_CYCLES_p < 2) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES_p must be at least 2");
  end
  state_t state, nxt;
  logic [ADDR_BW_p-1:0]   addr;
  logic [DATA_BW_p-1:0]   wdata, rdata;
  logic [DATA_BW_p/8-1:0] wstrb;
  logic [1:0]             resp;
  logic write, aw_done, w_done, aw_hs, w_hs, tmo_hit, timed_out;
`ifdef AXI_LITE_MASTER_TIMEOUT_EN
  logic busy, expired;
  assign busy    = state inside {WRITE, WR_RESP, RD_ADDR, RD_DATA};
  assign tmo_hit = busy && expired;
  assign o_timeout = timed_out;
  axi_lite_master_timer #(.CYCLES_p(TIMEOUT_CYCLES_p)) u_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .enable (busy),
    .clear  (o_cmd_ready && i_cmd_valid),
    .expired(expired)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) timed_out <= 1'b0;
    else if (tmo_hit) timed_out <= 1'b1;
`else
  assign tmo_hit   = 1'b0;
  assign timed_out = 1'b0;
`endif
  // Valids/readys decode from state alone, so async reset clears them at once.
  assign o_cmd_ready   = state == IDLE;
  assign o_axi_awvalid = state == WRITE && !aw_done;
  assign o_axi_wvalid  = state == WRITE && !w_done;
  assign o_axi_bready  = state == WR_RESP;
  assign o_axi_arvalid = state == RD_ADDR;
  assign o_axi_rready  = state == RD_DATA;
  assign o_rsp_valid   = state == RSP;
  assign aw_hs = o_axi_awvalid && i_axi_awready;
  assign w_hs  = o_axi_wvalid && i_axi_wready;
  assign o_axi_awaddr = addr;
  assign o_axi_araddr = addr;
  assign o_axi_wdata  = wdata;
  assign o_axi_wstrb  = wstrb;
  assign o_rsp_write  = write;
  assign o_rsp_rdata  = rdata;
  assign o_rsp_resp   = resp;
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    nxt = i_cmd_valid ? (i_cmd_write ? WRITE : RD_ADDR) : IDLE;
      WRITE:   nxt = (aw_done || aw_hs) && (w_done || w_hs) ? WR_RESP : WRITE;
      WR_RESP: nxt = i_axi_bvalid ? RSP : WR_RESP;
      RD_ADDR: nxt = i_axi_arready ? RD_DATA : RD_ADDR;
      RD_DATA: nxt = i_axi_rvalid ? RSP : RD_DATA;
      RSP:     nxt = i_rsp_ready ? (timed_out ? HUNG : IDLE) : RSP;
      default: nxt = state;
    endcase
    if (tmo_hit) nxt = RSP;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= nxt;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      addr    <= '0;
      wdata   <= '0;
      wstrb   <= '0;
      write   <= 1'b0;
      aw_done <= 1'b0;
      w_done  <= 1'b0;
      rdata   <= '0;
      resp    <= RESP_OKAY;
    end else begin
      if (o_cmd_ready && i_cmd_valid) begin
        addr    <= i_cmd_addr;
        wdata   <= i_cmd_wdata;
        wstrb   <= i_cmd_wstrb;
        write   <= i_cmd_write;
        aw_done <= 1'b0;
        w_done  <= 1'b0;
      end
      if (aw_hs) aw_done <= 1'b1;
      if (w_hs) w_done <= 1'b1;
      if (o_axi_bready && i_axi_bvalid) begin
        rdata <= '0;
        resp  <= i_axi_bresp;
      end
      if (o_axi_rready && i_axi_rvalid) begin
        rdata <= i_axi_rdata;
        resp  <= i_axi_rresp;
      end
      if (tmo_hit) begin
        rdata <= '0;
        resp  <= RESP_DECERR;
      end
    end
endmodule

// File: tb/tb_axi_lite_master.sv
// tb_axi_lite_master: scoreboard bench with a behavioural AXI-Lite slave with programmable ready delays.
// Define AXI_LITE_MASTER_TIMEOUT_EN to also exercise the timeout/HUNG path.
module tb_axi_lite_master;
  import axi_lite_pkg::*;
  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;
  logic        i_cmd_valid = 1'b0, o_cmd_ready, i_cmd_write = 1'b0;
  logic [11:0] i_cmd_addr = '0;
  logic [31:0] i_cmd_wdata = '0;
  logic [3:0]  i_cmd_wstrb = '0;
  logic        o_rsp_valid, i_rsp_ready, o_rsp_write;
  logic [31:0] o_rsp_rdata;
  logic [1:0]  o_rsp_resp;
  logic [11:0] o_axi_awaddr, o_axi_araddr;
  logic        o_axi_awvalid, i_axi_awready, o_axi_wvalid, i_axi_wready;
  logic [31:0] o_axi_wdata, i_axi_rdata;
  logic [3:0]  o_axi_wstrb;
  logic [1:0]  i_axi_bresp, i_axi_rresp;
  logic        i_axi_bvalid, o_axi_bready, o_axi_arvalid, i_axi_arready;
  logic        i_axi_rvalid, o_axi_rready;
`ifdef AXI_LITE_MASTER_TIMEOUT_EN
  logic        o_timeout;
`endif
  axi_lite_master #(.ADDR_BW_p(12), .DATA_BW_p(32), .TIMEOUT_CYCLES_p(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_cmd_valid(i_cmd_valid), .o_cmd_ready(o_cmd_ready), .i_cmd_write(i_cmd_write),
    .i_cmd_addr(i_cmd_addr), .i_cmd_wdata(i_cmd_wdata), .i_cmd_wstrb(i_cmd_wstrb),
    .o_rsp_valid(o_rsp_valid), .i_rsp_ready(i_rsp_ready), .o_rsp_write(o_rsp_write),
    .o_rsp_rdata(o_rsp_rdata), .o_rsp_resp(o_rsp_resp),
    .o_axi_awaddr(o_axi_awaddr), .o_axi_awvalid(o_axi_awvalid), .i_axi_awready(i_axi_awready),
    .o_axi_wdata(o_axi_wdata), .o_axi_wstrb(o_axi_wstrb), .o_axi_wvalid(o_axi_wvalid),
    .i_axi_wready(i_axi_wready),
    .i_axi_bresp(i_axi_bresp), .i_axi_bvalid(i_axi_bvalid), .o_axi_bready(o_axi_bready),
    .o_axi_araddr(o_axi_araddr), .o_axi_arvalid(o_axi_arvalid), .i_axi_arready(i_axi_arready),
    .i_axi_rdata(i_axi_rdata), .i_axi_rresp(i_axi_rresp), .i_axi_rvalid(i_axi_rvalid),
    .o_axi_rready(o_axi_rready)
`ifdef AXI_LITE_MASTER_TIMEOUT_EN
    ,.o_timeout(o_timeout)
`endif
  );
  int compared = 0, mismatched = 0, cyc = 0, last_hs = -1;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask
  typedef struct {
    logic        write;
    logic [31:0] rdata;
    logic [1:0]  resp;
    int          acc;
    int          lat;
  } exp_t;
  exp_t sbq[$];
  int aw_dly = 0, w_dly = 0, rsp_stall = 0, b_cnt = 0;
  bit hang_b = 0;
  logic [11:0] cur_addr = '0;
  logic [31:0] cur_wdata = '0;
  logic [3:0]  cur_wstrb = '0;
  logic [31:0] mem [0:1023];
  // Slave: handshakes computed at a negedge complete on the following posedge.
  initial begin
    int aw_wait, w_wait;
    bit aw_hs, w_hs, ar_hs, b_hs, r_hs, got_aw, got_w;
    logic [11:0] s_awaddr, s_araddr;
    logic [31:0] s_wdata;
    logic [3:0]  s_wstrb;
    {i_axi_awready, i_axi_wready, i_axi_arready, i_axi_bvalid, i_axi_rvalid} = '0;
    i_axi_bresp = '0; i_axi_rresp = '0; i_axi_rdata = '0;
    {aw_wait, w_wait} = '0;
    {aw_hs, w_hs, ar_hs, b_hs, r_hs, got_aw, got_w} = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        {i_axi_awready, i_axi_wready, i_axi_arready, i_axi_bvalid, i_axi_rvalid} = '0;
        {aw_wait, w_wait} = '0;
        {aw_hs, w_hs, ar_hs, b_hs, r_hs, got_aw, got_w} = '0;
        continue;
      end
      if (aw_hs) check("awvalid_drop", o_axi_awvalid, 0);
      if (w_hs) check("wvalid_drop", o_axi_wvalid, 0);
      if (b_hs) i_axi_bvalid = 1'b0;
      if (r_hs) i_axi_rvalid = 1'b0;
      if (ar_hs) begin
        i_axi_rvalid = 1'b1;
        i_axi_rdata  = s_araddr >= 12'h800 ? 32'hDEAD_DEAD : mem[s_araddr[11:2]];
        i_axi_rresp  = s_araddr >= 12'h800 ? RESP_SLVERR : RESP_OKAY;
      end
      if (got_aw && got_w) begin
        for (int i = 0; i < 4; i++)
          if (s_wstrb[i]) mem[s_awaddr[11:2]][i*8+:8] = s_wdata[i*8+:8];
        {got_aw, got_w} = '0;
        i_axi_bvalid = !hang_b;
        i_axi_bresp  = RESP_OKAY;
      end
      if (o_axi_awvalid) check("awaddr_stable", o_axi_awaddr, cur_addr);
      if (o_axi_wvalid) check("wpayload_stable", {o_axi_wstrb, o_axi_wdata}, {cur_wstrb, cur_wdata});
      if (o_axi_arvalid) check("araddr_stable", o_axi_araddr, cur_addr);
      aw_wait = o_axi_awvalid ? aw_wait + 1 : 0;
      w_wait  = o_axi_wvalid ? w_wait + 1 : 0;
      i_axi_awready = o_axi_awvalid && aw_wait > aw_dly;
      i_axi_wready  = o_axi_wvalid && w_wait > w_dly;
      i_axi_arready = o_axi_arvalid;
      aw_hs = o_axi_awvalid && i_axi_awready;
      w_hs  = o_axi_wvalid && i_axi_wready;
      ar_hs = o_axi_arvalid && i_axi_arready;
      b_hs  = i_axi_bvalid && o_axi_bready;
      r_hs  = i_axi_rvalid && o_axi_rready;
      if (aw_hs) begin got_aw = 1'b1; s_awaddr = o_axi_awaddr; end
      if (w_hs) begin got_w = 1'b1; s_wdata = o_axi_wdata; s_wstrb = o_axi_wstrb; end
      if (ar_hs) s_araddr = o_axi_araddr;
      if (b_hs) b_cnt++;
    end
  end
  // Response monitor: holds i_rsp_ready low for rsp_stall cycles, then pops the scoreboard.
  initial begin
    int cnt, first;
    logic [34:0] hold;
    exp_t e;
    cnt = 0; first = 0; hold = '0;
    i_rsp_ready = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin cnt = 0; i_rsp_ready = 1'b0; continue; end
      if (!o_rsp_valid) begin i_rsp_ready = 1'b0; continue; end
      check("cmd_ready_in_rsp", o_cmd_ready, 0);
      if (cnt == 0) begin
        first = cyc;
        hold = {o_rsp_write, o_rsp_resp, o_rsp_rdata};
      end else check("rsp_stable", {o_rsp_write, o_rsp_resp, o_rsp_rdata}, hold);
      cnt++;
      i_rsp_ready = cnt > rsp_stall;
      if (i_rsp_ready) begin
        check("sb_nonempty", sbq.size() != 0, 1);
        if (sbq.size() != 0) begin
          e = sbq.pop_front();
          check("rsp_write", o_rsp_write, e.write);
          check("rsp_rdata", o_rsp_rdata, e.rdata);
          check("rsp_resp", o_rsp_resp, e.resp);
          if (e.lat >= 0) check("rsp_latency", first - e.acc, e.lat);
        end
        last_hs = cyc;
        cnt = 0;
      end
    end
  end
  task automatic send(input logic w, input logic [11:0] a, input logic [31:0] d, input logic [3:0] s,
                      input logic [31:0] er, input logic [1:0] eresp, input int lat);
    int n = 0;
    @(negedge clk);
    i_cmd_valid = 1'b1; i_cmd_write = w; i_cmd_addr = a; i_cmd_wdata = d; i_cmd_wstrb = s;
    cur_addr = a; cur_wdata = d; cur_wstrb = s;
    while (!o_cmd_ready && n < 300) begin @(negedge clk); n++; end
    check("cmd_accept", o_cmd_ready, 1);
    check("accept_after_rsp", cyc > last_hs, 1);
    sbq.push_back('{w, er, eresp, cyc, lat});
    @(negedge clk);
    i_cmd_valid = 1'b0;
  endtask
  task automatic drain();
    int n = 0;
    while (sbq.size() != 0 && n < 500) begin @(negedge clk); n++; end
    check("drain", sbq.size(), 0);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end
  initial begin
    int b0;
    repeat (2) @(negedge clk);
    check("rst_awvalid", o_axi_awvalid, 0);
    check("rst_wvalid", o_axi_wvalid, 0);
    check("rst_arvalid", o_axi_arvalid, 0);
    check("rst_bready", o_axi_bready, 0);
    check("rst_rready", o_axi_rready, 0);
    check("rst_rsp_valid", o_rsp_valid, 0);
    check("rst_rsp_fields", {o_rsp_write, o_rsp_resp, o_rsp_rdata}, 0);
    check("rst_awaddr", o_axi_awaddr, 0);
    rst_n = 1'b1;
    send(1, 12'h040, 32'hDEAD_BEEF, 4'hF, 32'h0, RESP_OKAY, 3);
    send(0, 12'h040, 32'h0, 4'h0, 32'hDEAD_BEEF, RESP_OKAY, 3);
    drain();
    aw_dly = 0; w_dly = 3; b0 = b_cnt;
    send(1, 12'h044, 32'h1122_3344, 4'hF, 32'h0, RESP_OKAY, -1);
    drain();
    check("b_count_aw_first", b_cnt - b0, 1);
    aw_dly = 3; w_dly = 0; b0 = b_cnt;
    send(1, 12'h044, 32'hAABB_CCDD, 4'h5, 32'h0, RESP_OKAY, -1);
    drain();
    check("b_count_w_first", b_cnt - b0, 1);
    aw_dly = 0; w_dly = 0;
    send(0, 12'h044, 32'h0, 4'h0, 32'h11BB_33DD, RESP_OKAY, 3);
    send(0, 12'h900, 32'h0, 4'h0, 32'hDEAD_DEAD, RESP_SLVERR, 3);
    drain();
    rsp_stall = 5;
    send(1, 12'h048, 32'h1234_5678, 4'hF, 32'h0, RESP_OKAY, 3);
    send(0, 12'h048, 32'h0, 4'h0, 32'h1234_5678, RESP_OKAY, 3);
    drain();
    rsp_stall = 0;
    aw_dly = 100; w_dly = 100;
    send(1, 12'h080, 32'h5555_AAAA, 4'hF, 32'h0, RESP_OKAY, -1);
    repeat (2) @(negedge clk);
    check("aw_pending", {o_axi_awvalid, o_axi_wvalid}, 2'b11);
    #2 rst_n = 1'b0;
    #1 check("async_rst_valids", {o_axi_awvalid, o_axi_wvalid}, 2'b00);
    sbq.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    aw_dly = 0; w_dly = 0;
    @(negedge clk);
    check("idle_after_rst", {o_cmd_ready, o_axi_awvalid, o_axi_wvalid}, 3'b100);
    send(0, 12'h040, 32'h0, 4'h0, 32'hDEAD_BEEF, RESP_OKAY, 3);
    drain();
`ifdef AXI_LITE_MASTER_TIMEOUT_EN
    check("timeout_clear", o_timeout, 0);
    hang_b = 1;
    send(1, 12'h04C, 32'hCAFE_F00D, 4'hF, 32'h0, RESP_DECERR, -1);
    drain();
    repeat (5) @(negedge clk);
    check("timeout_flag", o_timeout, 1);
    check("hung_cmd_ready", o_cmd_ready, 0);
    check("hung_axi", {o_axi_awvalid, o_axi_wvalid, o_axi_arvalid, o_axi_bready, o_axi_rready}, 0);
    hang_b = 0;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("timeout_reset", {o_timeout, o_cmd_ready}, 2'b01);
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
